// File: rtl/rfphoenix_icmiss_ctrl_if.sv
// rfphoenix_icmiss_ctrl_if: instruction-cache miss controller bus bundle.
// Groups requester, memory and tag/data RAM signals.
//   master: the miss controller (drives req/dwr/twr/status).
//   slave:  the environment (requester, memory bus and cache RAMs).
// Requester:  miss, miss_adr, inv.
// Memory:     req, req_adr, ack, err, dat.
// Data RAM:   dwr, dbeat, ddat.
// Tag RAM:    twr, tipo.
// Shared:     tway.
// Status:     busy, done, fault.
interface rfphoenix_icmiss_ctrl_if #(
    parameter int BW = 3,
    parameter int WW = 2
);
    logic          miss;
    logic [31:0]   miss_adr;
    logic          inv;
    logic          req;
    logic [31:0]   req_adr;
    logic          ack;
    logic          err;
    logic [127:0]  dat;
    logic          dwr;
    logic [BW-1:0] dbeat;
    logic [127:0]  ddat;
    logic          twr;
    logic [WW-1:0] tway;
    logic [31:0]   tipo;
    logic          busy;
    logic          done;
    logic          fault;

    modport master (
        input  miss, miss_adr, inv, ack, err, dat,
        output req, req_adr, dwr, dbeat, ddat, twr, tway, tipo, busy, done, fault
    );

    modport slave (
        output miss, miss_adr, inv, ack, err, dat,
        input  req, req_adr, dwr, dbeat, ddat, twr, tway, tipo, busy, done, fault
    );
endinterface

// File: rtl/rfphoenix_icmiss_ctrl.sv
// rfphoenix_icmiss_ctrl: instruction-cache line fill controller.
// Fetches a missing 128-byte line one beat at a time. Each beat is written
// to the data RAM as it arrives. The tag is written once the whole line has
// arrived. The victim way comes from a per-index round-robin counter.
// Ports:
//   clk   - clock, rising edge.
//   rst_n - asynchronous active-low reset.
//   bus   - master side of rfphoenix_icmiss_ctrl_if.
module rfphoenix_icmiss_ctrl #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int BEATS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rfphoenix_icmiss_ctrl_if.master bus
);
    localparam int IW = $clog2(LINES);
    localparam int WW = $clog2(WAYS);
    localparam int BW = $clog2(BEATS);

    typedef enum logic [2:0] {IDLE, REQ, TAGWR, DONE, ABORT} state_t;

    state_t        state, nxt;
    logic [31:0]   line_adr;
    logic [BW-1:0] beat;
    logic [WW-1:0] victim;
    logic [WW-1:0] rr [LINES];

    logic good_ack, last;
    assign good_ack = state == REQ && bus.ack && !bus.err;
    assign last     = beat == BW'(BEATS - 1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.miss ? REQ : IDLE;
            REQ:     nxt = !bus.ack ? REQ : bus.err ? ABORT : last ? TAGWR : REQ;
            TAGWR:   nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            line_adr <= '0;
            beat     <= '0;
            victim   <= '0;
            for (int i = 0; i < LINES; i++) rr[i] <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.miss) begin
                // Masking keeps the whole address visible; bits [6:0] are always zero.
                line_adr <= bus.miss_adr & ~32'h7f;
                beat     <= '0;
                victim   <= rr[bus.miss_adr[7 +: IW]];
            end
            if (good_ack) beat <= beat + 1'b1;
            // Invalidate wins over the replacement advance of a concurrent tag write.
            if (bus.inv) for (int i = 0; i < LINES; i++) rr[i] <= '0;
            else if (state == TAGWR) rr[line_adr[7 +: IW]] <= rr[line_adr[7 +: IW]] + 1'b1;
        end
    end

    assign bus.req     = state == REQ;
    assign bus.req_adr = line_adr + (32'(beat) << 4);
    assign bus.dwr     = good_ack;
    assign bus.dbeat   = beat;
    assign bus.ddat    = good_ack ? bus.dat : '0;
    assign bus.twr     = state == TAGWR;
    assign bus.tway    = victim;
    assign bus.tipo    = line_adr;
    assign bus.busy    = state != IDLE;
    assign bus.done    = state == DONE;
    assign bus.fault   = state == ABORT;
endmodule
